// File: rtl/motor_ctrl_pkg.sv
// rtl/motor_ctrl_pkg.sv - shared motor-control types, also used by the SPI frame logic
package motor_ctrl_pkg;

  typedef enum logic [1:0] {POS = 2'd0, VEL = 2'd1, DISP = 2'd2, OFF = 2'd3} motorMode_t;

  typedef enum logic [2:0] {IDLE, LOAD, CALC, WRITE, SKIP, DONE} schedState_t;

  localparam int PWM_MAX_DEFAULT = 1023;

  typedef logic signed [31:0] data_t;

  // Signed 16x32 product, sign-extended to 48 bits and truncated to the low word
  function automatic data_t mulLow(input logic signed [15:0] k, input data_t x);
    logic signed [47:0] kx;
    logic signed [47:0] xx;
    logic signed [47:0] p;
    kx = k;
    xx = x;
    p = kx * xx;
    return p[31:0];
  endfunction

endpackage

// File: rtl/motor_pid_scheduler_pid_core.sv
// rtl/motor_pid_scheduler_pid_core.sv - shared 3-stage PID datapath, fixed latency 3
module pid_core
  import motor_ctrl_pkg::*;
#(
  parameter int SHIFT   = 7,
  parameter int PWM_MAX = PWM_MAX_DEFAULT
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  input  logic signed [31:0] iSP,
  input  logic signed [31:0] iFB,
  input  logic signed [31:0] iLAST_ERR,
  input  logic signed [15:0] iKP,
  input  logic signed [15:0] iKD,
  output logic               oVALID,
  output logic signed [31:0] oERR,
  output logic signed [31:0] oRES
);

  localparam data_t LIMIT = 32'(PWM_MAX);

  logic  v1, v2;
  data_t err1, hist1, err2, pterm2, dterm2;
  data_t sum, shifted, clamped;

  always_comb begin
    sum     = pterm2 + dterm2;
    shifted = sum >>> SHIFT;
    clamped = shifted;
    if (shifted > LIMIT) clamped = LIMIT;
    else if (shifted < -LIMIT) clamped = -LIMIT;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      oVALID <= 1'b0;
      err1   <= '0;
      hist1  <= '0;
      err2   <= '0;
      pterm2 <= '0;
      dterm2 <= '0;
      oERR   <= '0;
      oRES   <= '0;
    end else begin
      v1     <= iSTART;
      err1   <= iSP - iFB;
      hist1  <= iLAST_ERR;
      v2     <= v1;
      err2   <= err1;
      pterm2 <= mulLow(iKP, err1);
      dterm2 <= mulLow(iKD, err1 - hist1);
      oVALID <= v2;
      oERR   <= err2;
      oRES   <= clamped;
    end
  end

endmodule

// File: rtl/motor_pid_scheduler.sv
// rtl/motor_pid_scheduler.sv - walks N motor channels through one shared PID core per tick
module motor_pid_scheduler
  import motor_ctrl_pkg::*;
#(
  parameter int N_MOTORS = 4,
  parameter int SHIFT    = 7,
  parameter int PWM_MAX  = PWM_MAX_DEFAULT
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iTICK,
  input  logic [N_MOTORS-1:0]     iENABLE,
  input  logic [2*N_MOTORS-1:0]   iMODE,
  input  logic [32*N_MOTORS-1:0]  iSETPOINT,
  input  logic [32*N_MOTORS-1:0]  iPOSITION,
  input  logic [32*N_MOTORS-1:0]  iVELOCITY,
  input  logic [32*N_MOTORS-1:0]  iDISPLACEMENT,
  input  logic [15:0]             iKP,
  input  logic [15:0]             iKD,
  output logic [32*N_MOTORS-1:0]  oPWM,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic                    oOVERRUN
);

  localparam int CW = (N_MOTORS > 1) ? $clog2(N_MOTORS) : 1;

  schedState_t state, nextState;
  logic [CW-1:0] ch, probeCh;
  logic [1:0]    calcCnt;
  logic          lastCh, probeRun, startR;
  logic signed [15:0] kpR, kdR;
  data_t         lastErr [N_MOTORS];
  motorMode_t    lastMode [N_MOTORS];
  data_t         spR, fbR, histR, feedback;
  motorMode_t    modeR, curMode;
  logic          pidValid;
  data_t         pidErr, pidRes;

  assign lastCh  = (ch == CW'(N_MOTORS - 1));
  // Channel whose enable/mode decides the next slot type: 0 from IDLE, else ch+1
  assign probeCh  = (state == IDLE) ? '0 : ch + 1'b1;
  assign probeRun = iENABLE[probeCh] && (iMODE[2*probeCh +: 2] != 2'd3);
  assign curMode  = motorMode_t'(iMODE[2*ch +: 2]);

  always_comb begin
    feedback = '0;
    case (curMode)
      POS:     feedback = iPOSITION[32*ch +: 32];
      VEL:     feedback = iVELOCITY[32*ch +: 32];
      DISP:    feedback = iDISPLACEMENT[32*ch +: 32];
      default: feedback = '0;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:        if (iTICK) nextState = probeRun ? LOAD : SKIP;
      LOAD:        nextState = CALC;
      CALC:        if (calcCnt == 2'd2) nextState = WRITE;
      WRITE, SKIP: nextState = lastCh ? DONE : (probeRun ? LOAD : SKIP);
      DONE:        nextState = IDLE;
      default:     nextState = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state    <= IDLE;
      ch       <= '0;
      calcCnt  <= '0;
      kpR      <= '0;
      kdR      <= '0;
      spR      <= '0;
      fbR      <= '0;
      histR    <= '0;
      modeR    <= OFF;
      startR   <= 1'b0;
      oPWM     <= '0;
      oBUSY    <= 1'b0;
      oDONE    <= 1'b0;
      oOVERRUN <= 1'b0;
      for (int k = 0; k < N_MOTORS; k++) begin
        lastErr[k]  <= '0;
        lastMode[k] <= OFF;
      end
    end else begin
      state    <= nextState;
      oBUSY    <= (nextState != IDLE);
      oDONE    <= (nextState == DONE);
      oOVERRUN <= iTICK && (state != IDLE);
      startR   <= (state == LOAD);
      calcCnt  <= (state == CALC) ? calcCnt + 2'd1 : 2'd0;
      case (state)
        IDLE: if (iTICK) begin
          kpR <= iKP;
          kdR <= iKD;
          ch  <= '0;
        end
        LOAD: begin
          spR   <= iSETPOINT[32*ch +: 32];
          fbR   <= feedback;
          modeR <= curMode;
          // A mode change invalidates the derivative history of this channel
          histR <= (curMode != lastMode[ch]) ? '0 : lastErr[ch];
        end
        WRITE: begin
          if (pidValid) begin
            oPWM[32*ch +: 32] <= pidRes;
            lastErr[ch]       <= pidErr;
            lastMode[ch]      <= modeR;
          end
          ch <= ch + 1'b1;
        end
        SKIP: begin
          oPWM[32*ch +: 32] <= '0;
          lastErr[ch]       <= '0;
          lastMode[ch]      <= OFF;
          ch                <= ch + 1'b1;
        end
        default: ;
      endcase
    end
  end

  pid_core #(.SHIFT(SHIFT), .PWM_MAX(PWM_MAX)) uPidCore (
    .iCLK      (iCLK),
    .iRESET    (iRESET),
    .iSTART    (startR),
    .iSP       (spR),
    .iFB       (fbR),
    .iLAST_ERR (histR),
    .iKP       (kpR),
    .iKD       (kdR),
    .oVALID    (pidValid),
    .oERR      (pidErr),
    .oRES      (pidRes)
  );

endmodule

// File: tb/tb_motor_pid_scheduler.sv
// tb/tb_motor_pid_scheduler.sv - scoreboard bench for motor_pid_scheduler
module tb_motor_pid_scheduler;

  logic         clk;
  logic         iRESET, iTICK;
  logic [3:0]   iENABLE;
  logic [7:0]   iMODE;
  logic [127:0] iSETPOINT, iPOSITION, iVELOCITY, iDISPLACEMENT;
  logic [15:0]  iKP, iKD;
  logic [127:0] oPWM;
  logic         oBUSY, oDONE, oOVERRUN;

  motor_pid_scheduler #(.N_MOTORS(4), .SHIFT(7), .PWM_MAX(1023)) dut (
    .iCLK(clk), .iRESET(iRESET), .iTICK(iTICK), .iENABLE(iENABLE), .iMODE(iMODE),
    .iSETPOINT(iSETPOINT), .iPOSITION(iPOSITION), .iVELOCITY(iVELOCITY),
    .iDISPLACEMENT(iDISPLACEMENT), .iKP(iKP), .iKD(iKD),
    .oPWM(oPWM), .oBUSY(oBUSY), .oDONE(oDONE), .oOVERRUN(oOVERRUN)
  );

  typedef struct {
    logic [127:0] pwm;
    int           lat;
  } exp_t;

  exp_t sbQ[$];
  exp_t eCur;
  int   errors = 0, checks = 0;
  int   cyc = 0, tickEdge = 0, doneCnt = 0, ovCnt = 0;
  int   ovBefore, doneBefore;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  task automatic setCh(input int k, input int sp, input int pos, input int vel,
                       input int disp, input logic [1:0] mode, input logic en);
    iSETPOINT[32*k +: 32]     = sp;
    iPOSITION[32*k +: 32]     = pos;
    iVELOCITY[32*k +: 32]     = vel;
    iDISPLACEMENT[32*k +: 32] = disp;
    iMODE[2*k +: 2]           = mode;
    iENABLE[k]                = en;
  endtask

  // Monitor: pops one expectation per oDONE pulse and compares the whole result
  always @(negedge clk) begin
    if (oOVERRUN) ovCnt++;
    if (oDONE) begin
      doneCnt++;
      if (sbQ.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        eCur = sbQ.pop_front();
        for (int k = 0; k < 4; k++)
          check($sformatf("pwm%0d", k), $signed(oPWM[32*k +: 32]), $signed(eCur.pwm[32*k +: 32]));
        check("done_latency", cyc - tickEdge, eCur.lat);
        check("busy_at_done", int'(oBUSY), 1);
      end
    end
  end

  task automatic runRound(input logic [127:0] expPwm, input int lat, input int ovAt);
    int startDone;
    int n;
    exp_t e;
    e.pwm = expPwm;
    e.lat = lat;
    sbQ.push_back(e);
    startDone = doneCnt;
    @(negedge clk);
    iTICK = 1'b1;
    tickEdge = cyc + 1;
    @(negedge clk);
    iTICK = 1'b0;
    check("busy_rise", int'(oBUSY), 1);
    if (ovAt > 0) begin
      repeat (ovAt - 1) @(negedge clk);
      iTICK = 1'b1;
      @(negedge clk);
      iTICK = 1'b0;
    end
    n = 0;
    while (doneCnt == startDone && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (doneCnt == startDone) begin
      check("done_timeout", 0, 1);
      if (sbQ.size() > 0) void'(sbQ.pop_back());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    iRESET = 1'b1; iTICK = 1'b0; iENABLE = 4'hF; iMODE = '0;
    iSETPOINT = '0; iPOSITION = '0; iVELOCITY = '0; iDISPLACEMENT = '0;
    iKP = '0; iKD = '0;
    repeat (3) @(negedge clk);
    iRESET = 1'b0;
    @(negedge clk);
    check("rst_pwm_zero", int'(oPWM == '0), 1);
    check("rst_busy", int'(oBUSY), 0);
    check("rst_done", int'(oDONE), 0);
    check("rst_overrun", int'(oOVERRUN), 0);

    // Proportional only: scaling, clamp both ways, floor shift, feedback selection
    iKP = 16'd1; iKD = 16'd0;
    setCh(0, 1280, 0, 0, 0, 2'd0, 1'b1);
    setCh(1, 200000, 999999, 0, 0, 2'd1, 1'b1);
    setCh(2, -200000, -200000, 0, 0, 2'd2, 1'b1);
    setCh(3, -1281, 0, 0, 0, 2'd0, 1'b1);
    runRound(pack4(10, 1023, -1023, -11), 20, 0);

    setCh(0, -1280, 0, 0, 0, 2'd0, 1'b1);
    setCh(1, 7040, 999999, 0, 0, 2'd1, 1'b1);
    runRound(pack4(-10, 55, -1023, -11), 20, 0);

    // ch1 disabled: forced to zero, shorter round
    iENABLE = 4'b1101;
    runRound(pack4(-10, 0, -1023, -11), 16, 0);

    // Second tick mid-round is ignored but flagged
    iENABLE = 4'hF;
    ovBefore = ovCnt;
    runRound(pack4(-10, 55, -1023, -11), 20, 5);
    check("overrun_pulses", ovCnt - ovBefore, 1);

    // Reset during ch2 CALC abandons the round
    doneBefore = doneCnt;
    @(negedge clk);
    iTICK = 1'b1;
    @(negedge clk);
    iTICK = 1'b0;
    repeat (12) @(negedge clk);
    iRESET = 1'b1;
    @(negedge clk);
    check("midrst_pwm_zero", int'(oPWM == '0), 1);
    check("midrst_busy", int'(oBUSY), 0);
    iRESET = 1'b0;
    repeat (25) @(negedge clk);
    check("midrst_no_done", doneCnt - doneBefore, 0);

    // Derivative only: kick, steady state, history cleared by mode change
    iKP = 16'd0; iKD = 16'd2;
    setCh(0, 1280, 0, 0, 0, 2'd0, 1'b1);
    setCh(1, 0, 0, 0, 0, 2'd3, 1'b1);
    setCh(2, 0, 0, 0, 0, 2'd3, 1'b1);
    setCh(3, 0, 0, 0, 0, 2'd3, 1'b1);
    runRound(pack4(20, 0, 0, 0), 8, 0);
    runRound(pack4(0, 0, 0, 0), 8, 0);
    setCh(0, 1280, 777, 0, 0, 2'd1, 1'b1);
    runRound(pack4(20, 0, 0, 0), 8, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
